// File: rtl/trap_arbiter_pkg.sv
// trap_arbiter_pkg: cause codes, widths and FSM states shared by the trap arbiter
package trap_pkg;
  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] INSTR_MISALIGNED = 4'd0;
  localparam logic [CODE_W-1:0] ILLEGAL = 4'd2;
  localparam logic [CODE_W-1:0] LOAD_FAULT = 4'd5;
  localparam logic [CODE_W-1:0] STORE_FAULT = 4'd7;
  localparam logic [CODE_W-1:0] ECALL_M = 4'd11;
  localparam logic [CODE_W-1:0] MSI = 4'd3;
  localparam logic [CODE_W-1:0] MTI = 4'd7;
  localparam logic [CODE_W-1:0] MEI = 4'd11;
  localparam logic [CODE_W-1:0] SEI = 4'd9;
  typedef enum logic {ST_IDLE, ST_HANDLER} state_t;
endpackage

// File: rtl/trap_arbiter_if.sv
// trap_arbiter_if: fault/interrupt sources in, trap request and mip view out
interface trap_arbiter_if #(
  parameter int XLEN = 64,
  parameter int CODE_W = trap_pkg::CODE_W,
  parameter int N_EXC = 5,
  parameter int N_IRQ = 4
);
  logic [N_EXC-1:0] exc_en_i;
  logic [N_EXC*CODE_W-1:0] exc_code_i;
  logic [N_EXC*XLEN-1:0] exc_val_i;
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic global_ie;
  logic [N_IRQ-1:0] irq_clr;
  logic trap_taken;
  logic mret;
  logic exc_en;
  logic [CODE_W-1:0] exc_code;
  logic [XLEN-1:0] exc_val;
  logic irq_en;
  logic [CODE_W-1:0] irq_code;
  logic [XLEN-1:0] irq_val;
  logic [N_IRQ-1:0] irq_pending;
  logic in_handler;
  modport master (
    output exc_en_i, exc_code_i, exc_val_i, irq_in, irq_mask, global_ie, irq_clr, trap_taken, mret,
    input exc_en, exc_code, exc_val, irq_en, irq_code, irq_val, irq_pending, in_handler
  );
  modport slave (
    input exc_en_i, exc_code_i, exc_val_i, irq_in, irq_mask, global_ie, irq_clr, trap_taken, mret,
    output exc_en, exc_code, exc_val, irq_en, irq_code, irq_val, irq_pending, in_handler
  );
endinterface

// File: rtl/trap_arbiter_prio_enc.sv
// prio_enc: lowest-index-first priority encoder
module prio_enc #(
  parameter int N = 4,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic valid,
  output logic [W-1:0] idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/trap_arbiter.sv
// trap_arbiter: combinational exception select plus registered, masked interrupt
// arbitration that is blocked between trap entry and mret
module trap_arbiter import trap_pkg::*; #(
  parameter int XLEN = 64,
  parameter int CODE_W = trap_pkg::CODE_W,
  parameter int N_EXC = 5,
  parameter int N_IRQ = 4,
  parameter logic [N_IRQ-1:0] IRQ_EDGE = '0,
  parameter logic [N_IRQ*CODE_W-1:0] IRQ_CODES = 16'h937B
) (
  input logic clk,
  input logic rst,
  trap_arbiter_if.slave bus
);
  localparam int EW = N_EXC > 1 ? $clog2(N_EXC) : 1;
  localparam int IW = N_IRQ > 1 ? $clog2(N_IRQ) : 1;
  state_t r_state, w_state_n;
  logic [N_IRQ-1:0] r_pend, r_irq_q, w_pend_n, w_elig, w_take;
  logic w_exc_v, w_irq_v, w_irq_en;
  logic [EW-1:0] w_exc_idx;
  logic [IW-1:0] w_irq_idx;
  assign w_elig = r_pend & bus.irq_mask;
  prio_enc #(.N(N_EXC)) u_exc (.req(bus.exc_en_i), .valid(w_exc_v), .idx(w_exc_idx));
  prio_enc #(.N(N_IRQ)) u_irq (.req(w_elig), .valid(w_irq_v), .idx(w_irq_idx));
  // synchronous exceptions always pre-empt an interrupt request
  assign w_irq_en = (r_state == ST_IDLE) && bus.global_ie && w_irq_v && !w_exc_v;
  always_comb begin
    bus.exc_en = w_exc_v;
    bus.exc_code = w_exc_v ? bus.exc_code_i[w_exc_idx*CODE_W +: CODE_W] : '0;
    bus.exc_val = w_exc_v ? bus.exc_val_i[w_exc_idx*XLEN +: XLEN] : '0;
    bus.irq_en = w_irq_en;
    bus.irq_code = w_irq_en ? IRQ_CODES[w_irq_idx*CODE_W +: CODE_W] : '0;
    bus.irq_val = '0;
    bus.irq_pending = r_pend;
    bus.in_handler = r_state == ST_HANDLER;
    w_take = (bus.trap_taken && w_irq_en) ? N_IRQ'(1) << w_irq_idx : '0;
    // edge lines: a new rising edge beats any clear in the same cycle
    w_pend_n = (IRQ_EDGE & ((bus.irq_in & ~r_irq_q) | (r_pend & ~(bus.irq_clr | w_take))))
             | (~IRQ_EDGE & bus.irq_in);
  end
  always_comb begin
    w_state_n = r_state;
    if (r_state == ST_IDLE) w_state_n = bus.trap_taken ? ST_HANDLER : ST_IDLE;
    else w_state_n = (bus.mret && !bus.trap_taken) ? ST_IDLE : ST_HANDLER;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_pend <= '0;
      r_irq_q <= '0;
    end else begin
      r_state <= w_state_n;
      r_pend <= w_pend_n;
      r_irq_q <= bus.irq_in;
    end
endmodule

// File: tb/tb_trap_arbiter.sv
// tb_trap_arbiter: directed vector table plus hand sequences for the trap arbiter
module tb_trap_arbiter;
  localparam logic [63:0] C = 64'hCAFE_0000_0000_0000;
  typedef struct {
    logic [4:0] exc;
    logic [3:0] irq, msk;
    logic gie;
    logic [3:0] clr;
    logic tt, mr;
    logic e_en;
    logic [3:0] e_code;
    logic [63:0] e_val;
    logic i_en;
    logic [3:0] i_code;
    logic [3:0] pend;
    logic inh;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int n_vec = 0;
  int n_err = 0;
  vec_t tv[$];
  trap_arbiter_if bus ();
  trap_arbiter #(.IRQ_EDGE(4'b0001)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [4:0] exc, logic [3:0] irq, logic [3:0] msk, logic gie,
                              logic [3:0] clr, logic tt, logic mr, logic e_en, logic [3:0] e_code,
                              logic [63:0] e_val, logic i_en, logic [3:0] i_code, logic [3:0] pend,
                              logic inh);
    vec_t v;
    v = '{exc, irq, msk, gie, clr, tt, mr, e_en, e_code, e_val, i_en, i_code, pend, inh};
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_irq(string nm, logic en, logic [3:0] code, logic [3:0] pend, logic inh);
    chk({nm, " irq_en"}, 64'(bus.irq_en), 64'(en));
    chk({nm, " irq_code"}, 64'(bus.irq_code), 64'(code));
    chk({nm, " irq_pending"}, 64'(bus.irq_pending), 64'(pend));
    chk({nm, " in_handler"}, 64'(bus.in_handler), 64'(inh));
    chk({nm, " irq_val"}, bus.irq_val, 64'd0);
  endtask

  initial begin
    bus.exc_en_i = '0;
    bus.exc_code_i = 20'h27510;
    for (int i = 0; i < 5; i++) bus.exc_val_i[i*64 +: 64] = C | 64'(i);
    bus.irq_in = '0;
    bus.irq_mask = '0;
    bus.global_ie = 0;
    bus.irq_clr = '0;
    bus.trap_taken = 0;
    bus.mret = 0;
    //           exc       irq      msk     g  clr     tt mr  ee ec  ev     ie ic  pend   inh
    tv.push_back(mk(5'b10100, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 1, 5, C | 2, 0, 0, 4'b0000, 0));
    tv.push_back(mk(5'b10100, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 1, 5, C | 2, 0, 0, 4'b0010, 0));
    tv.push_back(mk(5'b00000, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 7, 4'b0010, 0));
    tv.push_back(mk(5'b00000, 4'b0010, 4'b0010, 1, 4'b0000, 1, 0, 0, 0, 0, 1, 7, 4'b0010, 0));
    tv.push_back(mk(5'b00000, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 1));
    tv.push_back(mk(5'b01000, 4'b0010, 4'b0010, 1, 4'b0000, 0, 1, 1, 7, C | 3, 0, 0, 4'b0010, 1));
    tv.push_back(mk(5'b00000, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 7, 4'b0010, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0));
    tv.push_back(mk(5'b00000, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 11, 4'b0001, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 11, 4'b0001, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 1, 0, 0, 0, 0, 1, 11, 4'b0001, 0));
    tv.push_back(mk(5'b10000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 0, 1, 2, C | 4, 0, 0, 4'b0000, 1));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 1));
    tv.push_back(mk(5'b00000, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 11, 4'b0001, 0));
    tv.push_back(mk(5'b00000, 4'b0001, 4'b0001, 1, 4'b0001, 0, 0, 0, 0, 0, 1, 11, 4'b0001, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 11, 4'b0001, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0001, 0, 0, 0, 0, 0, 1, 11, 4'b0001, 0));
    tv.push_back(mk(5'b00000, 4'b0000, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    tv.push_back(mk(5'b00000, 4'b0101, 4'b0101, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 11, 4'b0101, 0));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 1, 4'b0000, 1, 0, 0, 0, 0, 1, 11, 4'b0101, 0));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 1));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'b0100, 1));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 3, 4'b0100, 0));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 3, 4'b0100, 0));
    tv.push_back(mk(5'b00000, 4'b0101, 4'b0101, 1, 4'b0000, 1, 0, 0, 0, 0, 1, 3, 4'b0100, 0));
    tv.push_back(mk(5'b00000, 4'b0100, 4'b0101, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 1));

    @(negedge clk);
    #1;
    chk_irq("reset", 0, 0, 4'b0000, 0);
    chk("reset exc_en", 64'(bus.exc_en), 64'd0);
    rst = 0;
    foreach (tv[k]) begin
      @(negedge clk);
      bus.exc_en_i = tv[k].exc;
      bus.irq_in = tv[k].irq;
      bus.irq_mask = tv[k].msk;
      bus.global_ie = tv[k].gie;
      bus.irq_clr = tv[k].clr;
      bus.trap_taken = tv[k].tt;
      bus.mret = tv[k].mr;
      #1;
      chk($sformatf("v%0d exc_en", k), 64'(bus.exc_en), 64'(tv[k].e_en));
      chk($sformatf("v%0d exc_code", k), 64'(bus.exc_code), 64'(tv[k].e_code));
      chk($sformatf("v%0d exc_val", k), bus.exc_val, tv[k].e_val);
      chk_irq($sformatf("v%0d", k), tv[k].i_en, tv[k].i_code, tv[k].pend, tv[k].inh);
    end
    // async reset while in the handler with lines 0 and 2 pending
    @(negedge clk);
    rst = 1;
    #1;
    chk_irq("rst mid-handler", 0, 0, 4'b0000, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk_irq("after rst", 0, 0, 4'b0000, 0);
    @(negedge clk);
    #1;
    chk_irq("recover", 1, 3, 4'b0100, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
